// File: rtl/nonce_sweeper.sv
// Job controller for the double-SHA256 core: sweeps a nonce range and reports hashes <= target.
// Define NONCE_SWEEPER_BSWAP_EN to compare the byte-reversed hash (Bitcoin numeric order).
module nonce_sweeper #(
    parameter int unsigned WAIT_TIMEOUT  = 1023,
    parameter bit          STOP_ON_FOUND = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [607:0] job_prefix,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    input  logic         abort,
    output logic         core_rst_n,
    output logic         core_start,
    output logic [639:0] core_block,
    input  logic [255:0] core_hash,
    input  logic         core_done,
    output logic         found_valid,
    input  logic         found_ready,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash,
    output logic         busy,
    output logic         exhausted,
    output logic         timeout_err
);

    localparam int unsigned TW = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CRST, S_START, S_WAIT, S_CHECK, S_REPORT, S_NEXT
    } state_t;

    state_t         state_q, state_d;
    logic [607:0]   prefix_q, prefix_d;
    logic [31:0]    nonce_q, nonce_d;
    logic [31:0]    end_q, end_d;
    logic [255:0]   target_q, target_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           rstn_q, rstn_d;
    logic           fvalid_q, fvalid_d;
    logic [31:0]    fnonce_q, fnonce_d;
    logic [255:0]   fhash_q, fhash_d;
    logic           terr_q, terr_d;
    logic [255:0]   cmp_hash;
    logic           last;

    always_comb begin
        cmp_hash = core_hash;
`ifdef NONCE_SWEEPER_BSWAP_EN
        for (int unsigned i = 0; i < 32; i++) begin
            cmp_hash[8*i +: 8] = core_hash[8*(31-i) +: 8];
        end
`endif
    end

    assign last = (nonce_q == end_q);

    always_comb begin
        state_d  = state_q;
        prefix_d = prefix_q;
        nonce_d  = nonce_q;
        end_d    = end_q;
        target_d = target_q;
        timer_d  = timer_q;
        rstn_d   = 1'b1;
        fvalid_d = fvalid_q;
        fnonce_d = fnonce_q;
        fhash_d  = fhash_q;
        terr_d   = terr_q;
        unique case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    prefix_d = job_prefix;
                    nonce_d  = nonce_start;
                    end_d    = nonce_end;
                    target_d = target;
                    terr_d   = 1'b0;
                    rstn_d   = 1'b0;
                    state_d  = S_CRST;
                end
            end
            S_CRST: begin
                // timer holds cycles elapsed since the start pulse
                timer_d = '0;
                state_d = S_START;
            end
            S_START: begin
                timer_d = timer_q + 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    state_d = S_CHECK;
                end else if (timer_q == TW'(WAIT_TIMEOUT)) begin
                    terr_d  = 1'b1;
                    rstn_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (cmp_hash <= target_q) begin
                    fnonce_d = nonce_q;
                    fhash_d  = core_hash;
                    fvalid_d = 1'b1;
                    state_d  = S_REPORT;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_REPORT: begin
                if (found_ready) begin
                    fvalid_d = 1'b0;
                    state_d  = (STOP_ON_FOUND || last) ? S_IDLE : S_NEXT;
                end
            end
            S_NEXT: begin
                if (last) begin
                    state_d = S_IDLE;
                end else begin
                    nonce_d = nonce_q + 32'd1;
                    rstn_d  = 1'b0;
                    state_d = S_CRST;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // abort overrides whatever the state wanted, including a same-cycle timeout
        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            fvalid_d = 1'b0;
            rstn_d   = 1'b0;
            terr_d   = terr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            prefix_q <= '0;
            nonce_q  <= '0;
            end_q    <= '0;
            target_q <= '0;
            timer_q  <= '0;
            rstn_q   <= 1'b1;
            fvalid_q <= 1'b0;
            fnonce_q <= '0;
            fhash_q  <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prefix_q <= prefix_d;
            nonce_q  <= nonce_d;
            end_q    <= end_d;
            target_q <= target_d;
            timer_q  <= timer_d;
            rstn_q   <= rstn_d;
            fvalid_q <= fvalid_d;
            fnonce_q <= fnonce_d;
            fhash_q  <= fhash_d;
            terr_q   <= terr_d;
        end
    end

    assign job_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign core_start  = (state_q == S_START);
    assign core_rst_n  = rstn_q;
    assign core_block  = {prefix_q, nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]};
    assign found_valid = fvalid_q;
    assign found_nonce = fnonce_q;
    assign found_hash  = fhash_q;
    assign exhausted   = (state_q == S_NEXT) && last && !abort;
    assign timeout_err = terr_q;

endmodule
